// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: instruction field positions, opcode constants, FSM states,
// ALU-op encoding and the opcode decoder shared by the cpu_mc core.
// Optional feature macro: CPU_SHIFT_EN (adds sll/srl/sra/ror, opcodes 13-16).
package cpu_mc_pkg;

   // Instruction word layout: [31:24] opcode, [23:16] rd/offset, [15:8] rt, [7:0] rs/imm
   localparam int FIELD_W = 8;
   localparam int OPC_LSB = 24;
   localparam int RD_LSB  = 16;
   localparam int RT_LSB  = 8;
   localparam int RS_LSB  = 0;

   localparam logic [7:0] OP_LOADI = 8'd0;
   localparam logic [7:0] OP_MOV   = 8'd1;
   localparam logic [7:0] OP_ADD   = 8'd2;
   localparam logic [7:0] OP_SUB   = 8'd3;
   localparam logic [7:0] OP_AND   = 8'd4;
   localparam logic [7:0] OP_OR    = 8'd5;
   localparam logic [7:0] OP_J     = 8'd6;
   localparam logic [7:0] OP_BEQ   = 8'd7;
   localparam logic [7:0] OP_LWD   = 8'd8;
   localparam logic [7:0] OP_LWI   = 8'd9;
   localparam logic [7:0] OP_SWD   = 8'd10;
   localparam logic [7:0] OP_SWI   = 8'd11;
   localparam logic [7:0] OP_BNE   = 8'd12;
`ifdef CPU_SHIFT_EN
   localparam logic [7:0] OP_SLL   = 8'd13;
   localparam logic [7:0] OP_SRL   = 8'd14;
   localparam logic [7:0] OP_SRA   = 8'd15;
   localparam logic [7:0] OP_ROR   = 8'd16;
`endif

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM} state_t;

   typedef enum logic [3:0] {
      ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR
   } alu_op_t;

   typedef enum logic [1:0] {BR_NONE, BR_JUMP, BR_EQ, BR_NE} br_kind_t;

   // Control bundle for the instruction held in IR.
   typedef struct packed {
      logic     legal;
      logic     writes_rd;  // ALU result goes to rd in EXEC
      logic     use_imm;    // operand / address comes from imm instead of rs
      logic     is_load;
      logic     is_store;
      br_kind_t br;
      alu_op_t  alu_op;
   } decode_t;

   function automatic decode_t decode(input logic [7:0] opcode);
      decode_t d;
      d        = '0;
      d.br     = BR_NONE;
      d.alu_op = ALU_PASS;
      d.legal  = 1'b1;
      case (opcode)
         OP_LOADI: begin d.writes_rd = 1'b1; d.use_imm = 1'b1; end
         OP_MOV:   d.writes_rd = 1'b1;
         OP_ADD:   begin d.writes_rd = 1'b1; d.alu_op = ALU_ADD; end
         OP_SUB:   begin d.writes_rd = 1'b1; d.alu_op = ALU_SUB; end
         OP_AND:   begin d.writes_rd = 1'b1; d.alu_op = ALU_AND; end
         OP_OR:    begin d.writes_rd = 1'b1; d.alu_op = ALU_OR;  end
         OP_J:     d.br = BR_JUMP;
         OP_BEQ:   d.br = BR_EQ;
         OP_BNE:   d.br = BR_NE;
         OP_LWD:   d.is_load = 1'b1;
         OP_LWI:   begin d.is_load = 1'b1;  d.use_imm = 1'b1; end
         OP_SWD:   d.is_store = 1'b1;
         OP_SWI:   begin d.is_store = 1'b1; d.use_imm = 1'b1; end
`ifdef CPU_SHIFT_EN
         OP_SLL:   begin d.writes_rd = 1'b1; d.alu_op = ALU_SLL; end
         OP_SRL:   begin d.writes_rd = 1'b1; d.alu_op = ALU_SRL; end
         OP_SRA:   begin d.writes_rd = 1'b1; d.alu_op = ALU_SRA; end
         OP_ROR:   begin d.writes_rd = 1'b1; d.alu_op = ALU_ROR; end
`endif
         default:  d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu_mc_reg_file.sv
// cpu_mc_reg_file: DATA_W x 2**REG_ADDR_W register file with two asynchronous
// read ports, one synchronous write port and an asynchronous active-low clear.
module cpu_mc_reg_file #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0]     rdata_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0]     rdata_b
);

   localparam int DEPTH = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   // Clear every register on reset, otherwise write at most one per cycle.
   // NOTE: the array is reset on purpose: programs may read any register before writing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle CPU (FETCH -> EXEC [-> MEM]) with instruction and data
// busywait handshakes, jumps, conditional branches and load/store.
// Optional feature macro: CPU_SHIFT_EN (shift/rotate opcodes 13-16).
module cpu_mc
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET_N,
   output logic [31:0]       PC,
   input  logic [31:0]       INSTRUCTION,
   input  logic              I_BUSYWAIT,
   output logic              D_READ,
   output logic              D_WRITE,
   output logic [DATA_W-1:0] D_ADDR,
   output logic [DATA_W-1:0] D_WDATA,
   input  logic [DATA_W-1:0] D_RDATA,
   input  logic              D_BUSYWAIT,
   output logic              ILLEGAL
);

   state_t                state, state_nxt;
   logic [31:0]           ir;
   decode_t               dec;
   logic [FIELD_W-1:0]    opcode, offset, imm;
   logic [REG_ADDR_W-1:0] rd_addr, rt_addr, rs_addr;
   logic [DATA_W-1:0]     rt_val, rs_val, imm_ext, op_b, alu_res, rf_wdata;
   logic                  rf_we, take_branch;
   logic [31:0]           pc_plus4, br_target;
   logic                  unused_ir;

   // Instruction fields; register fields use only their low REG_ADDR_W bits.
   assign opcode  = ir[OPC_LSB +: FIELD_W];
   assign offset  = ir[RD_LSB  +: FIELD_W];
   assign imm     = ir[RS_LSB  +: FIELD_W];
   assign rd_addr = ir[RD_LSB  +: REG_ADDR_W];
   assign rt_addr = ir[RT_LSB  +: REG_ADDR_W];
   assign rs_addr = ir[RS_LSB  +: REG_ADDR_W];
   assign imm_ext = DATA_W'(imm);
   // High register-field bits are don't-care for small register files.
   assign unused_ir = ^ir;

   assign dec = decode(opcode);

   cpu_mc_reg_file #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_reg_file (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .we      (rf_we),
      .waddr   (rd_addr),
      .wdata   (rf_wdata),
      .raddr_a (rt_addr),
      .rdata_a (rt_val),
      .raddr_b (rs_addr),
      .rdata_b (rs_val)
   );

   // Next-PC arithmetic; the 32-bit adders wrap naturally.
   assign pc_plus4    = PC + 32'd4;
   assign br_target   = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
   assign take_branch = (dec.br == BR_JUMP)
                     || (dec.br == BR_EQ && rt_val == rs_val)
                     || (dec.br == BR_NE && rt_val != rs_val);

   assign op_b = dec.use_imm ? imm_ext : rs_val;

`ifdef CPU_SHIFT_EN
   int shamt;
   assign shamt = int'(imm) % DATA_W;
`endif

   // ALU: rd <- f(rt, rs/imm); subtraction is two's-complement addition.
   always_comb begin
      alu_res = op_b;
      case (dec.alu_op)
         ALU_ADD: alu_res = rt_val + op_b;
         ALU_SUB: alu_res = rt_val + (~op_b + 1'b1);
         ALU_AND: alu_res = rt_val & op_b;
         ALU_OR:  alu_res = rt_val | op_b;
`ifdef CPU_SHIFT_EN
         ALU_SLL: alu_res = rt_val << shamt;
         ALU_SRL: alu_res = rt_val >> shamt;
         ALU_SRA: alu_res = $unsigned($signed(rt_val) >>> shamt);
         ALU_ROR: alu_res = (rt_val >> shamt) | (rt_val << (DATA_W - shamt));
`endif
         default: alu_res = op_b;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_FETCH;
      else          state <= state_nxt;
   end

   // Next-state logic plus register-file write control and the ILLEGAL pulse.
   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      rf_we     = 1'b0;
      rf_wdata  = alu_res;
      ILLEGAL   = 1'b0;
      case (state)
         ST_FETCH: if (!I_BUSYWAIT) state_nxt = ST_EXEC;
         ST_EXEC: begin
            ILLEGAL = !dec.legal;
            if (dec.is_load || dec.is_store) begin
               state_nxt = ST_MEM;
            end else begin
               state_nxt = ST_FETCH;
               rf_we     = dec.writes_rd;
            end
         end
         ST_MEM: begin
            if (!D_BUSYWAIT) begin
               state_nxt = ST_FETCH;
               rf_we     = dec.is_load;
               rf_wdata  = D_RDATA;
            end
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   // Datapath registers: IR capture, PC update and the registered memory strobes.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PC      <= '0;
         ir      <= '0;
         D_READ  <= 1'b0;
         D_WRITE <= 1'b0;
         D_ADDR  <= '0;
         D_WDATA <= '0;
      end else begin
         case (state)
            ST_FETCH: if (!I_BUSYWAIT) ir <= INSTRUCTION;
            ST_EXEC: begin
               if (dec.is_load || dec.is_store) begin
                  D_READ  <= dec.is_load;
                  D_WRITE <= dec.is_store;
                  D_ADDR  <= op_b;
                  D_WDATA <= rt_val;
               end else begin
                  PC <= take_branch ? br_target : pc_plus4;
               end
            end
            ST_MEM: begin
               if (!D_BUSYWAIT) begin
                  D_READ  <= 1'b0;
                  D_WRITE <= 1'b0;
                  PC      <= pc_plus4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
